// File: rtl/cache_way_alloc_if.sv
// Allocation/touch/invalidate bundle between the cache controller and the way allocator.
interface cache_way_alloc_if #(parameter int sets_p = 16);
  localparam int set_width_lp = $clog2(sets_p);

  logic                    alloc_v_i;
  logic [set_width_lp-1:0] alloc_set_i;
  logic                    alloc_ready_o;
  logic                    alloc_v_o;
  logic [1:0]              alloc_way_o;
  logic [3:0]              alloc_way_oh_o;
  logic                    alloc_yumi_i;
  logic                    touch_v_i;
  logic [set_width_lp-1:0] touch_set_i;
  logic [1:0]              touch_way_i;
  logic                    inv_v_i;
  logic [set_width_lp-1:0] inv_set_i;
  logic [1:0]              inv_way_i;

  modport master (
    output alloc_v_i, alloc_set_i, alloc_yumi_i,
    output touch_v_i, touch_set_i, touch_way_i,
    output inv_v_i, inv_set_i, inv_way_i,
    input  alloc_ready_o, alloc_v_o, alloc_way_o, alloc_way_oh_o
  );

  modport slave (
    input  alloc_v_i, alloc_set_i, alloc_yumi_i,
    input  touch_v_i, touch_set_i, touch_way_i,
    input  inv_v_i, inv_set_i, inv_way_i,
    output alloc_ready_o, alloc_v_o, alloc_way_o, alloc_way_oh_o
  );
endinterface

// File: rtl/cache_way_alloc.sv
// Per-set 4-way valid + tree-PLRU tracker; picks a refill victim and returns it
// as both an index and a one-hot way write-enable.
module cache_way_alloc #(parameter int sets_p = 16) (
  input logic              clk_i,
  input logic              reset_i,
  cache_way_alloc_if.slave io
);
  localparam int set_width_lp = $clog2(sets_p);

  typedef enum logic [1:0] {INIT, IDLE, RESP} state_e;

  state_e                  state_r, state_n;
  logic [set_width_lp-1:0] cnt_r;
  logic [3:0]              valid_r [sets_p];
  logic [2:0]              plru_r  [sets_p];
  logic [3:0]              vbits;
  logic [2:0]              pbits;
  logic [1:0]              victim;
  logic                    accept;
  logic                    v_r;
  logic [1:0]              way_r;
  logic [3:0]              oh_r;

  // Touch points the tree away from the used way; untouched subtree bit is kept.
  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] r;
    r = p;
    case (w)
      2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
      2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
      2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
      default: begin r[0] = 1'b0; r[2] = 1'b0; end
    endcase
    return r;
  endfunction

  always_comb begin
    vbits  = valid_r[io.alloc_set_i];
    pbits  = plru_r[io.alloc_set_i];
    victim = 2'd0;
    if      (!vbits[0]) victim = 2'd0;
    else if (!vbits[1]) victim = 2'd1;
    else if (!vbits[2]) victim = 2'd2;
    else if (!vbits[3]) victim = 2'd3;
    else                victim = pbits[0] ? {1'b1, pbits[2]} : {1'b0, pbits[1]};
  end

  // Hit and invalidate traffic always wins over a new allocation.
  assign io.alloc_ready_o = (state_r == IDLE) & ~io.touch_v_i & ~io.inv_v_i;
  assign accept           = io.alloc_v_i & io.alloc_ready_o;

  always_comb begin
    state_n = state_r;
    case (state_r)
      INIT:    if (cnt_r == set_width_lp'(sets_p - 1)) state_n = IDLE;
      IDLE:    if (accept) state_n = RESP;
      RESP:    if (io.alloc_yumi_i) state_n = IDLE;
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= INIT;
      cnt_r   <= '0;
      v_r     <= 1'b0;
      way_r   <= 2'd0;
      oh_r    <= 4'd0;
    end else begin
      state_r <= state_n;
      if (state_r == INIT) cnt_r <= cnt_r + 1'b1;
      if (accept) begin
        v_r   <= 1'b1;
        way_r <= victim;
        oh_r  <= 4'b0001 << victim;
      end else if (state_r == RESP && io.alloc_yumi_i) begin
        v_r <= 1'b0;
      end
    end
  end

  // Tag-side state is cleared by the INIT sweep rather than by reset directly.
  always_ff @(posedge clk_i) begin
    if (state_r == INIT) begin
      valid_r[cnt_r] <= 4'd0;
      plru_r[cnt_r]  <= 3'd0;
    end else begin
      if (accept) begin
        valid_r[io.alloc_set_i][victim] <= 1'b1;
        plru_r[io.alloc_set_i]          <= plru_touch(pbits, victim);
      end
      if (io.touch_v_i)
        plru_r[io.touch_set_i] <= plru_touch(plru_r[io.touch_set_i], io.touch_way_i);
      if (io.inv_v_i)
        valid_r[io.inv_set_i][io.inv_way_i] <= 1'b0;
    end
  end

  assign io.alloc_v_o      = v_r;
  assign io.alloc_way_o    = way_r;
  assign io.alloc_way_oh_o = oh_r;
endmodule

// File: tb/tb_cache_way_alloc.sv
// Directed bench for cache_way_alloc; allocations push expected victims into a
// scoreboard that a negedge monitor drains as results appear.
module tb_cache_way_alloc;
  logic clk = 1'b0;
  logic reset_i = 1'b1;

  cache_way_alloc_if #(.sets_p(16)) io();
  cache_way_alloc #(.sets_p(16)) dut (.clk_i(clk), .reset_i(reset_i), .io(io));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] way;
    logic [3:0] oh;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop on each new result, then hold it against the output while valid.
  initial begin
    exp_t cur;
    logic prev_v;
    prev_v = 1'b0;
    cur.way = 2'd0;
    cur.oh  = 4'd0;
    forever begin
      @(negedge clk);
      if (io.alloc_v_o === 1'b1) begin
        if (!prev_v) begin
          if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_result: got way %0d with empty scoreboard", io.alloc_way_o);
          end else begin
            cur = q.pop_front();
            check("result_way", 8'(io.alloc_way_o), 8'(cur.way));
            check("result_oh", 8'(io.alloc_way_oh_o), 8'(cur.oh));
          end
        end else begin
          check("hold_way", 8'(io.alloc_way_o), 8'(cur.way));
          check("hold_oh", 8'(io.alloc_way_oh_o), 8'(cur.oh));
        end
      end
      prev_v = (io.alloc_v_o === 1'b1);
    end
  end

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic do_alloc(input int set, input logic [1:0] way, input logic [3:0] oh,
                          input int hold, input bit consume);
    exp_t e;
    bit   got;
    e.way = way;
    e.oh  = oh;
    q.push_back(e);
    io.alloc_set_i = 4'(set);
    io.alloc_v_i   = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (io.alloc_ready_o === 1'b1) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      check("alloc_ready_timeout", 8'd0, 8'd1);
      io.alloc_v_i = 1'b0;
      void'(q.pop_back());
      return;
    end
    @(posedge clk); #1;
    io.alloc_v_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("ready_in_resp", 8'(io.alloc_ready_o), 8'd0);
      @(posedge clk); #1;
    end
    if (consume) begin
      io.alloc_yumi_i = 1'b1;
      @(negedge clk);
      check("ready_during_yumi", 8'(io.alloc_ready_o), 8'd0);
      @(posedge clk); #1;
      io.alloc_yumi_i = 1'b0;
      @(negedge clk);
      check("v_after_yumi", 8'(io.alloc_v_o), 8'd0);
      check("ready_after_yumi", 8'(io.alloc_ready_o), 8'd1);
      @(posedge clk); #1;
    end
  endtask

  // One cycle of touch and/or invalidate, optionally with a competing allocation.
  task automatic side_op(input bit tv, input int tset, input logic [1:0] tway,
                         input bit iv, input int iset, input logic [1:0] iway, input bit av);
    io.touch_v_i   = tv;
    io.touch_set_i = 4'(tset);
    io.touch_way_i = tway;
    io.inv_v_i     = iv;
    io.inv_set_i   = 4'(iset);
    io.inv_way_i   = iway;
    io.alloc_v_i   = av;
    io.alloc_set_i = 4'(tset);
    @(negedge clk);
    check("ready_blocked_by_side_op", 8'(io.alloc_ready_o), 8'd0);
    @(posedge clk); #1;
    io.touch_v_i = 1'b0;
    io.inv_v_i   = 1'b0;
    io.alloc_v_i = 1'b0;
    @(negedge clk);
    check("no_accept_on_side_op", 8'(io.alloc_v_o), 8'd0);
    @(posedge clk); #1;
  endtask

  task automatic reset_seq();
    reset_i = 1'b1;
    @(posedge clk); #1;
    check("v_after_reset", 8'(io.alloc_v_o), 8'd0);
    check("oh_after_reset", 8'(io.alloc_way_oh_o), 8'd0);
    check("way_after_reset", 8'(io.alloc_way_o), 8'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("ready_during_init", 8'(io.alloc_ready_o), 8'd0);
      check("v_during_init", 8'(io.alloc_v_o), 8'd0);
    end
    @(negedge clk);
    check("ready_after_init", 8'(io.alloc_ready_o), 8'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    io.alloc_v_i = 1'b0;  io.alloc_set_i = '0; io.alloc_yumi_i = 1'b0;
    io.touch_v_i = 1'b0;  io.touch_set_i = '0; io.touch_way_i  = 2'd0;
    io.inv_v_i   = 1'b0;  io.inv_set_i   = '0; io.inv_way_i    = 2'd0;
    @(posedge clk); #1;
    reset_seq();

    // Fill set 3 through invalid ways, then replace via PLRU.
    do_alloc(3, 2'd0, 4'b0001, 0, 1'b1);
    do_alloc(3, 2'd1, 4'b0010, 0, 1'b1);
    do_alloc(3, 2'd2, 4'b0100, 0, 1'b1);
    do_alloc(3, 2'd3, 4'b1000, 0, 1'b1);
    do_alloc(3, 2'd0, 4'b0001, 0, 1'b1);
    do_alloc(3, 2'd2, 4'b0100, 0, 1'b1);

    // Invalid way beats PLRU; then touch way 3 while requesting (blocked).
    side_op(1'b0, 3, 2'd0, 1'b1, 3, 2'd1, 1'b0);
    do_alloc(3, 2'd1, 4'b0010, 0, 1'b1);
    side_op(1'b1, 3, 2'd3, 1'b0, 0, 2'd0, 1'b1);
    do_alloc(3, 2'd0, 4'b0001, 0, 1'b1);

    // Held result on a fresh set.
    do_alloc(5, 2'd0, 4'b0001, 5, 1'b1);

    // Touch and invalidate the same set in one cycle: both take effect.
    do_alloc(9, 2'd0, 4'b0001, 0, 1'b1);
    do_alloc(9, 2'd1, 4'b0010, 0, 1'b1);
    do_alloc(9, 2'd2, 4'b0100, 0, 1'b1);
    do_alloc(9, 2'd3, 4'b1000, 0, 1'b1);
    side_op(1'b1, 9, 2'd0, 1'b1, 9, 2'd3, 1'b0);
    do_alloc(9, 2'd3, 4'b1000, 0, 1'b1);
    do_alloc(9, 2'd1, 4'b0010, 0, 1'b1);

    // Reset while a result is held, then every set starts again at way 0.
    do_alloc(3, 2'd2, 4'b0100, 2, 1'b0);
    reset_seq();
    for (int s = 0; s < 16; s++) do_alloc(s, 2'd0, 4'b0001, 0, 1'b1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_way_alloc.md
Name: cache_way_alloc

Overview:
- Per-set 4-way allocation and replacement tracker for the cache.
- Decodes a chosen way index back into a one-hot way write-enable.
- Holds valid bits and 3-bit tree pseudo-LRU state for each set, selects a victim on request, and tracks hits (touch) and invalidations.
- Sits beside the cache tag/data arrays; its one-hot output drives the per-way write enables on refill.

Parameters:
sets_p, 16, number of cache sets; power of 2, >= 2
set_width_lp, $clog2(sets_p), set index width (derived, not overridable)

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
alloc_v_i  input  1  allocation request valid
alloc_set_i  input  set_width_lp  set to allocate in
alloc_ready_o  output  1  allocation request accepted this cycle when high with alloc_v_i
alloc_v_o  output  1  victim result valid
alloc_way_o  output  2  victim way index
alloc_way_oh_o  output  4  one-hot decode of alloc_way_o (bit n set for way n)
alloc_yumi_i  input  1  consumer takes the result
touch_v_i  input  1  hit update valid
touch_set_i  input  set_width_lp  hit set
touch_way_i  input  2  hit way
inv_v_i  input  1  invalidate valid
inv_set_i  input  set_width_lp  invalidate set
inv_way_i  input  2  invalidate way

Behaviour:
- FSM states: INIT, IDLE, RESP.
- Reset: reset_i=1 forces, on the next edge, state=INIT, sweep counter=0, alloc_v_o=0, alloc_way_o=0, alloc_way_oh_o=0. This applies from any state, including RESP; a pending result is dropped.
- INIT:
  - Each cycle clears valid[cnt]=4'b0 and plru[cnt]=3'b0, then cnt++.
  - After clearing set sets_p-1, the FSM moves to IDLE.
  - alloc_ready_o is 0 for exactly sets_p cycles after reset_i deasserts.
  - touch and inv are ignored in INIT.
- alloc_ready_o = (state==IDLE) & ~touch_v_i & ~inv_v_i. It is combinational; touch and inv have priority over allocation.
- Accepting an allocation (alloc_v_i & alloc_ready_o):
  - Victim = lowest-index invalid way of the set if any valid bit is 0; otherwise the PLRU victim.
  - Registers alloc_way_o and alloc_way_oh_o, sets alloc_v_o=1, and enters RESP. Result is visible the cycle after acceptance (latency 1).
  - In the same edge, sets valid[set][victim]=1 and applies the touch update for the victim.
- PLRU encoding, bits {b2,b1,b0}:
  - b0=0 selects pair {0,1}; b0=1 selects pair {2,3}.
  - b1 selects way 0 (0) or way 1 (1); b2 selects way 2 (0) or way 3 (1).
- Touch update, applied to the chosen set:
  - way 0: b0=1, b1=1
  - way 1: b0=1, b1=0
  - way 2: b0=0, b2=1
  - way 3: b0=0, b2=0
  - Other bits are unchanged.
- RESP:
  - alloc_v_o, alloc_way_o and alloc_way_oh_o stay stable until alloc_yumi_i=1.
  - On yumi the FSM returns to IDLE and alloc_v_o=0 next cycle. The earliest next acceptance is the cycle after that (no back-to-back).
  - touch and inv are still serviced in RESP.
- touch_v_i (IDLE or RESP): updates the PLRU of touch_set_i per the table. Valid bits are unchanged.
- inv_v_i (IDLE or RESP): clears valid[inv_set_i][inv_way_i]. PLRU is unchanged.
- touch and inv in the same cycle: both apply, even to the same set. inv writes only valid bits and touch writes only PLRU bits, so they never conflict.
- Invalidating the way currently held in RESP: output is unaffected; the consumer owns that conflict.
- alloc_way_oh_o is always exactly one-hot while alloc_v_o=1, and 0 after reset.

Test Plan:
- Reset with sets_p=16 -> alloc_ready_o=0 for 16 cycles after reset_i falls, 1 on the 17th; alloc_v_o=0 throughout.
- Four allocations to set 3, each yumi'd immediately -> ways 0,1,2,3 with one-hot 0001,0010,0100,1000.
- Fifth allocation to set 3 (all ways valid) -> way 0 (oh 0001). Sixth -> way 2 (oh 0100), since PLRU is {b2=0,b1=1,b0=1} after way 0's update.
- inv set 3 way 1, then allocate set 3 -> way 1 (oh 0010) regardless of PLRU. touch set 3 way 3 with alloc_v_i high in the same cycle -> alloc_ready_o=0, request not accepted.
- Allocate, hold alloc_yumi_i=0 for 5 cycles -> alloc_v_o=1 with way/oh unchanged; alloc_ready_o=0 until the cycle after yumi.
- Assert reset_i during RESP -> alloc_v_o=0 next cycle, INIT sweep restarts, and every set then allocates way 0 first.
